station_seek: RTL and testbench

- Seek/scan controller that sequences the DDS tuning word K fed to radio_core.
- On a seek request it steps K across the FM band, waits for the demodulator to settle, and averages a signal-level input over a dwell window.
- It stops at the first channel whose average level meets the threshold.
- Sits between freq_select (manual preset K) and radio_core; runs on clk240m with the 32 kHz enable (en32k).

---
 rtl/station_seek.sv | 214 +++++++++++++++++++++
 tb/tb_station_seek.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/station_seek.sv
// -----------------------------------------------------------------------------
// station_seek
//   Seek/scan controller that sequences the DDS tuning word K fed to
//   radio_core. A seek pulse steps K one channel at a time across the FM band
//   (wrapping at the band edges). On each channel it waits SETTLE enable ticks
//   for the demodulator, then averages `level` over 2**LOG2_DWELL enable ticks.
//   The seek stops on the first channel whose average meets `threshold`, or
//   after the whole band has been covered and K is back at its start value.
//
// Optional feature (macro SEEK_MUTE_EN):
//   defined   : mute = busy, plus a hold of SETTLE enable ticks after preset_load
//   undefined : mute tied low, no hold counter
//
// Ports
//   clk          system clock (clk240m)
//   reset        asynchronous, active-high reset
//   en           one-clk timing enable; settle/dwell counters advance only on en
//   preset_k     manual tuning word from freq_select
//   preset_load  one-clk pulse: K <= preset_k, abort any seek (highest priority)
//   seek_up      one-clk pulse: start seek toward K_MAX (wins over seek_down)
//   seek_down    one-clk pulse: start seek toward K_MIN
//   level        unsigned carrier level, sampled on every en while measuring
//   threshold    lock threshold compared against the dwell average
//   K            tuning word to radio_core
//   busy         seek in progress
//   locked       last seek ended on a station
//   not_found    last seek covered the full band without a station
//   mute         audio mute request
//   dbg_state    current controller state (IDLE=0 STEP=1 SETTLE=2 MEASURE=3
//                DECIDE=4) for observation only
//
// Handshake: there is no valid/ready flow; seek_up/seek_down are accepted only
// while busy=0 and are otherwise dropped, preset_load is always accepted.
// -----------------------------------------------------------------------------
module station_seek #(
  parameter int                   width_dds   = 32,
  parameter int                   width_level = 16,
  parameter logic [width_dds-1:0] K_MIN       = '0,
  parameter logic [width_dds-1:0] K_MAX       = 32'hFFFF_F000,
  parameter logic [width_dds-1:0] K_STEP      = 32'h100,
  parameter int                   SETTLE      = 64,
  parameter int                   LOG2_DWELL  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [width_dds-1:0]   preset_k,
  input  logic                   preset_load,
  input  logic                   seek_up,
  input  logic                   seek_down,
  input  logic [width_level-1:0] level,
  input  logic [width_level-1:0] threshold,
  output logic [width_dds-1:0]   K,
  output logic                   busy,
  output logic                   locked,
  output logic                   not_found,
  output logic                   mute,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STEP    = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_DECIDE  = 3'd4
  } state_t;

  localparam int DWELL   = 1 << LOG2_DWELL;
  localparam int ACC_W   = width_level + LOG2_DWELL;
  localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL - 1);

  state_t               r_state;
  logic [width_dds-1:0] r_k;
  logic [width_dds-1:0] r_start_k;
  logic                 r_dir_up;
  logic                 r_busy;
  logic                 r_locked;
  logic                 r_not_found;
  logic [CNT_W-1:0]     r_cnt;      // shared: settle ticks, then dwell samples
  logic [ACC_W-1:0]     r_acc;

  // Next-channel arithmetic is done one bit wider so that the band-edge
  // comparisons cannot be fooled by a carry out of width_dds bits.
  logic [width_dds:0]   w_up_sum;
  logic [width_dds:0]   w_down_lim;
  logic [width_dds-1:0] w_next_k;
  logic [ACC_W-1:0]     w_avg;
  logic                 w_hit;

  assign w_up_sum   = {1'b0, r_k} + {1'b0, K_STEP};
  assign w_down_lim = {1'b0, K_MIN} + {1'b0, K_STEP};

  always_comb begin
    w_next_k = r_k - K_STEP;
    if (r_dir_up) begin
      if (w_up_sum > {1'b0, K_MAX}) w_next_k = K_MIN;
      else                          w_next_k = w_up_sum[width_dds-1:0];
    end else begin
      if ({1'b0, r_k} < w_down_lim) w_next_k = K_MAX;
      else                          w_next_k = r_k - K_STEP;
    end
  end

  assign w_avg = r_acc >> LOG2_DWELL;
  assign w_hit = (w_avg >= {{LOG2_DWELL{1'b0}}, threshold});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k         <= K_MIN;
      r_start_k   <= K_MIN;
      r_dir_up    <= 1'b1;
      r_busy      <= 1'b0;
      r_locked    <= 1'b0;
      r_not_found <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
    end else if (preset_load) begin
      // Manual tuning aborts everything; a simultaneous seek pulse is dropped.
      r_state     <= S_IDLE;
      r_k         <= preset_k;
      r_busy      <= 1'b0;
      r_locked    <= 1'b0;
      r_not_found <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (seek_up || seek_down) begin
            r_dir_up    <= seek_up;
            r_start_k   <= r_k;
            r_locked    <= 1'b0;
            r_not_found <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_STEP;
          end
        end
        S_STEP: begin
          r_k     <= w_next_k;
          r_cnt   <= '0;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (en) begin
            if (r_cnt == SETTLE_LAST) begin
              r_cnt   <= '0;
              r_acc   <= '0;
              r_state <= S_MEASURE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_MEASURE: begin
          if (en) begin
            r_acc <= r_acc + {{LOG2_DWELL{1'b0}}, level};
            if (r_cnt == DWELL_LAST) begin
              r_cnt   <= '0;
              r_state <= S_DECIDE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DECIDE: begin
          if (w_hit) begin
            r_locked <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_k == r_start_k) begin
            // Back where we started: the full band has been measured.
            r_not_found <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_STEP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SEEK_MUTE_EN
  // Keeps audio muted while the demodulator settles on a manually loaded K.
  logic [CNT_W-1:0] r_mute_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mute_cnt <= '0;
    end else if (preset_load) begin
      r_mute_cnt <= CNT_W'(SETTLE);
    end else if (en && (r_mute_cnt != '0)) begin
      r_mute_cnt <= r_mute_cnt - CNT_W'(1);
    end
  end

  assign mute = r_busy | (r_mute_cnt != '0);
`else
  assign mute = 1'b0;
`endif

  assign K         = r_k;
  assign busy      = r_busy;
  assign locked    = r_locked;
  assign not_found = r_not_found;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_station_seek.sv
module tb_station_seek;

  localparam int          WD      = 32;
  localparam int          WL      = 16;
  localparam int          SETTLE  = 4;
  localparam int          L2D     = 2;
  localparam int          DWELL   = 4;
  localparam int          EN_DIV  = 3;
  localparam int          NCH     = 17;
  localparam int          BUDGET  = 3000;
  localparam logic [31:0] KMIN    = 32'h0;
  localparam logic [31:0] KMAX    = 32'h1000;
  localparam logic [31:0] KSTEP   = 32'h100;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [WD-1:0] preset_k = '0;
  logic          preset_load = 1'b0;
  logic          seek_up = 1'b0;
  logic          seek_down = 1'b0;
  logic [WL-1:0] level = '0;
  logic [WL-1:0] threshold = '0;
  logic [WD-1:0] K;
  logic          busy;
  logic          locked;
  logic          not_found;
  logic          mute;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  station_seek #(
    .width_dds(WD), .width_level(WL), .K_MIN(KMIN), .K_MAX(KMAX),
    .K_STEP(KSTEP), .SETTLE(SETTLE), .LOG2_DWELL(L2D)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .preset_k(preset_k),
    .preset_load(preset_load), .seek_up(seek_up), .seek_down(seek_down),
    .level(level), .threshold(threshold), .K(K), .busy(busy),
    .locked(locked), .not_found(not_found), .mute(mute), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] base_lv[NCH];
  bit          par = 1'b0;

  // Channel level model: a station channel has a base level; samples alternate
  // base-3 / base+4 on successive en ticks, so any 4-sample window sums to
  // 4*base+2 and its truncated average is exactly base.
  function automatic logic [15:0] level_of(input logic [31:0] k, input bit p);
    int b;
    if (k[7:0] != 8'h0 || k > KMAX) return 16'd0;
    b = int'(base_lv[k[12:8]]);
    if (b < 3) return 16'(b);
    return p ? 16'(b + 4) : 16'(b - 3);
  endfunction

  function automatic int avg_of(input logic [31:0] k);
    if (k[7:0] != 8'h0 || k > KMAX) return 0;
    return int'(base_lv[k[12:8]]);
  endfunction

  function automatic logic mute_exp(input logic b);
`ifdef SEEK_MUTE_EN
    return b;
`else
    return b & 1'b0;
`endif
  endfunction

  // en every EN_DIV clocks; level follows the currently tuned channel.
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      if (en) par = ~par;
      en  = (div == 0);
      div = (div + 1) % EN_DIV;
      level = level_of(K, par);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference seek: walk channels by the band rules until a hit or a full lap.
  task automatic build_exp(input logic [31:0] start, input bit up, input logic [15:0] thr,
                           output logic [31:0] fk, output bit lk, output bit nf);
    logic [31:0] k;
    exp_q.delete();
    k  = start;
    lk = 1'b0;
    nf = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if (up) k = (longint'(k) + longint'(KSTEP) > longint'(KMAX)) ? KMIN : k + KSTEP;
      else    k = (longint'(k) < longint'(KMIN) + longint'(KSTEP)) ? KMAX : k - KSTEP;
      exp_q.push_back(k);
      if (avg_of(k) >= int'(thr)) begin lk = 1'b1; break; end
      if (k == start) begin nf = 1'b1; break; end
    end
    fk = k;
  endtask

  task automatic do_preset(input logic [31:0] pk);
    @(negedge clk);
    preset_k    = pk;
    preset_load = 1'b1;
    @(negedge clk);
    preset_load = 1'b0;
  endtask

  // ---------------- driver: one complete seek ----------------
  task automatic run_seek(input logic [31:0] start, input bit up, input bit dn,
                          input logic [15:0] thr, input bit inject,
                          output logic [31:0] ak, output bit alk, output bit anf);
    logic [31:0] fk, prev;
    bit          lk, nf;
    int          cyc, nchg, last_cyc, gap;
    threshold = thr;
    do_preset(start);
    check("preset_k", K, start);
    check("preset_mute", mute, mute_exp(1'b1));
    repeat (SETTLE * EN_DIV + 4) @(negedge clk);
    check("idle_mute", mute, 1'b0);
    build_exp(start, up, thr, fk, lk, nf);
    seek_up   = up;
    seek_down = dn;
    @(negedge clk);
    seek_up   = 1'b0;
    seek_down = 1'b0;
    check("busy_rise", busy, 1'b1);
    check("busy_mute", mute, mute_exp(1'b1));
    check("k_hold_1clk", K, start);
    prev = K; cyc = 0; nchg = 0; last_cyc = 0;
    while (busy && cyc < BUDGET) begin
      seek_down = inject && (cyc == 30);   // must be ignored while busy
      @(negedge clk);
      cyc++;
      if (K != prev) begin
        if (exp_q.size() == 0) check("k_seq_extra", K, prev);
        else                   check("k_seq", K, exp_q.pop_front());
        if (nchg == 0) check("first_k_latency", cyc, 1);
        if (nchg == 1) begin
          gap = cyc - last_cyc;
          check("chan_gap", (gap >= (SETTLE + DWELL - 1) * EN_DIV + 3) &&
                            (gap <= (SETTLE + DWELL) * EN_DIV + 2), 1);
        end
        last_cyc = cyc;
        nchg++;
        prev = K;
      end
    end
    seek_down = 1'b0;
    if (cyc >= BUDGET) check("seek_timeout", busy, 1'b0);
    check("k_seq_left", exp_q.size(), 0);
    check("final_k", K, fk);
    check("final_locked", locked, lk);
    check("final_not_found", not_found, nf);
    check("final_busy", busy, 1'b0);
    check("final_mute", mute, 1'b0);
    ak = K; alk = locked; anf = not_found;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] start;
    bit          up;
    bit          dn;
    logic [15:0] thr;
    int          st_a;
    int          st_b;
    logic [15:0] st_lv;
    logic [15:0] bg;
    bit          inject;
    logic [31:0] exp_k;
    bit          exp_lock;
    bit          exp_nf;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] ak;
    bit          alk, anf;
    int          guard;

    tbl[0] = '{32'h800, 1, 0, 16'd100, 10, -1, 16'd200, 16'd50, 0, 32'hA00,  1, 0};
    tbl[1] = '{32'hF80, 1, 0, 16'd100,  1, -1, 16'd200, 16'd50, 0, 32'h100,  1, 0};
    tbl[2] = '{32'h800, 0, 1, 16'd100, -1, -1, 16'd0,   16'd0,  0, 32'h800,  0, 1};
    tbl[3] = '{32'h300, 1, 0, 16'd100,  5, -1, 16'd100, 16'd50, 0, 32'h500,  1, 0};
    tbl[4] = '{32'h300, 1, 0, 16'd101,  5, -1, 16'd100, 16'd50, 0, 32'h300,  0, 1};
    tbl[5] = '{32'h800, 1, 1, 16'd100,  7,  9, 16'd200, 16'd50, 0, 32'h900,  1, 0};
    tbl[6] = '{32'h100, 0, 1, 16'd100, 16, -1, 16'd200, 16'd50, 0, 32'h1000, 1, 0};
    tbl[7] = '{32'h400, 0, 1, 16'd0,   -1, -1, 16'd0,   16'd0,  0, 32'h300,  1, 0};
    tbl[8] = '{32'h200, 1, 0, 16'd100,  6, -1, 16'd200, 16'd50, 1, 32'h600,  1, 0};
    tbl[9] = '{32'h800, 1, 0, 16'd100,  8, -1, 16'd200, 16'd50, 0, 32'h800,  1, 0};

    // Reset state
    for (int i = 0; i < NCH; i++) base_lv[i] = 16'd0;
    #1 reset = 1'b1;
    #20;
    check("rst_k", K, KMIN);
    check("rst_busy", busy, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_not_found", not_found, 1'b0);
    check("rst_mute", mute, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Table-driven seeks
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < NCH; i++) base_lv[i] = tbl[t].bg;
      if (tbl[t].st_a >= 0) base_lv[tbl[t].st_a] = tbl[t].st_lv;
      if (tbl[t].st_b >= 0) base_lv[tbl[t].st_b] = tbl[t].st_lv;
      run_seek(tbl[t].start, tbl[t].up, tbl[t].dn, tbl[t].thr, tbl[t].inject, ak, alk, anf);
      check("tbl_k", ak, tbl[t].exp_k);
      check("tbl_locked", alk, tbl[t].exp_lock);
      check("tbl_not_found", anf, tbl[t].exp_nf);
    end

    // Randomized seeks against the reference model
    for (int r = 0; r < 12; r++) begin
      logic [31:0] st;
      bit          up;
      for (int i = 0; i < NCH; i++) base_lv[i] = 16'($urandom_range(0, 300));
      st = 32'($urandom_range(0, NCH - 1)) << 8;
      up = 1'($urandom_range(0, 1));
      run_seek(st, up, ~up, 16'($urandom_range(0, 400)), 1'b0, ak, alk, anf);
    end

    // preset_load during SETTLE with a simultaneous seek_up
    for (int i = 0; i < NCH; i++) base_lv[i] = 16'd50;
    threshold = 16'd100;
    do_preset(32'h800);
    repeat (SETTLE * EN_DIV + 4) @(negedge clk);
    seek_up = 1'b1;
    @(negedge clk);
    seek_up = 1'b0;
    repeat (4) @(negedge clk);
    check("in_settle_busy", busy, 1'b1);
    check("in_settle_k", K, 32'h900);
    preset_k    = 32'h1234;
    preset_load = 1'b1;
    seek_up     = 1'b1;
    @(negedge clk);
    preset_load = 1'b0;
    seek_up     = 1'b0;
    check("abort_k", K, 32'h1234);
    check("abort_busy", busy, 1'b0);
    check("abort_locked", locked, 1'b0);
    check("abort_not_found", not_found, 1'b0);
    check("abort_mute", mute, mute_exp(1'b1));
    repeat (5) @(negedge clk);
    check("abort_seek_ignored_busy", busy, 1'b0);
    check("abort_seek_ignored_k", K, 32'h1234);
    // Out-of-band preset: the next up step wraps to K_MIN
    seek_up = 1'b1;
    @(negedge clk);
    seek_up = 1'b0;
    check("oob_busy", busy, 1'b1);
    @(negedge clk);
    check("oob_wrap_k", K, KMIN);
    do_preset(32'h800);
    check("oob_abort_busy", busy, 1'b0);

    // Asynchronous reset in the middle of MEASURE on K=0x300
    threshold = 16'd1000;
    do_preset(32'h200);
    repeat (SETTLE * EN_DIV + 4) @(negedge clk);
    seek_up = 1'b1;
    @(negedge clk);
    seek_up = 1'b0;
    guard = 0;
    while (!(K == 32'h300 && dbg_state == 3'd3) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("reach_measure", guard < 500, 1);
    #1 reset = 1'b1;
    #1;
    check("arst_k", K, KMIN);
    check("arst_busy", busy, 1'b0);
    check("arst_locked", locked, 1'b0);
    check("arst_not_found", not_found, 1'b0);
    check("arst_mute", mute, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle_k", K, KMIN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
